// File: rtl/dino_jump_ctrl_if.sv
// Signal bundle between the game sequencer and the dino jump controller.
// The sequencer drives the strobes and buttons; the controller returns motion state and height.
interface dino_jump_ctrl_if #(
  parameter int HW = 10
);
  logic          frameTick;
  logic [1:0]    gameState;
  logic          jumpBtn;
  logic          duckBtn;
  logic          Airborne;
  logic          onGround;
  logic          isDuck;
  logic [HW-1:0] dinoHeight;
  logic          landPulse;

  modport master (
    output frameTick, gameState, jumpBtn, duckBtn,
    input  Airborne, onGround, isDuck, dinoHeight, landPulse
  );

  modport slave (
    input  frameTick, gameState, jumpBtn, duckBtn,
    output Airborne, onGround, isDuck, dinoHeight, landPulse
  );
endinterface

// File: rtl/dino_jump_ctrl.sv
// Per-frame jump/duck physics for the dino sprite: integrates height and velocity on
// each frame tick while playing, and reports the motion state to the sprite FSM.
//
// state    | meaning
// S_GROUND | standing on the ground, height 0
// S_RISE   | airborne, velocity > 0
// S_FALL   | airborne, velocity <= 0
module dino_jump_ctrl #(
  parameter int HW       = 10,
  parameter int VW       = 6,
  parameter int JUMP_VEL = 14,
  parameter int GRAVITY  = 1,
  parameter int FASTFALL = 3,
  parameter int MIN_VEL  = 6,
  parameter int TERM_VEL = 15
) (
  input logic             clk,
  input logic             rst,
  dino_jump_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    S_GROUND = 2'd0,
    S_RISE   = 2'd1,
    S_FALL   = 2'd2
  } state_t;

  localparam logic signed [VW-1:0] JUMP_V   = VW'(JUMP_VEL);
  localparam logic signed [VW-1:0] MIN_V    = VW'(MIN_VEL);
  localparam logic signed [VW:0]   GRAV_X   = (VW+1)'(GRAVITY);
  localparam logic signed [VW:0]   FF_X     = (VW+1)'(FASTFALL);
  localparam logic signed [VW:0]   TERM_NEG = (VW+1)'(-TERM_VEL);

  state_t                state_q, state_d;
  logic [HW-1:0]         h_q, h_d;
  logic signed [VW-1:0]  v_q, v_d;
  logic                  jump_req_q, jump_req_d;
  logic                  jump_btn_dly_q, jump_btn_dly_d;
  logic                  land_q, land_d;

  logic                  jump_rise;
  logic signed [VW-1:0]  v_eff;
  logic signed [VW:0]    v_ext;
  logic signed [VW:0]    v_dec;
  logic signed [HW:0]    h_sum;

  always_comb begin
    state_d        = state_q;
    h_d            = h_q;
    v_d            = v_q;
    land_d         = 1'b0;
    jump_btn_dly_d = bus.jumpBtn;
    jump_rise      = bus.jumpBtn & ~jump_btn_dly_q;
    jump_req_d     = bus.frameTick ? 1'b0 : (jump_req_q | jump_rise);
    v_eff          = v_q;
    v_ext          = '0;
    v_dec          = '0;
    h_sum          = '0;

    case (bus.gameState)
      2'b10: begin
        if (bus.frameTick) begin
          if (state_q == S_GROUND) begin
            if (jump_req_q | jump_rise) begin
              state_d = S_RISE;
              v_d     = JUMP_V;
            end
          end else begin
            // releasing the button early caps the climb for a short hop
            if ((state_q == S_RISE) && !bus.jumpBtn && (v_q > MIN_V))
              v_eff = MIN_V;
            h_sum = $signed({1'b0, h_q}) + {{(HW+1-VW){v_eff[VW-1]}}, v_eff};
            if (h_sum[HW] || (h_sum == '0)) begin
              state_d = S_GROUND;
              h_d     = '0;
              v_d     = '0;
              land_d  = 1'b1;
            end else begin
              h_d   = h_sum[HW-1:0];
              v_ext = {v_eff[VW-1], v_eff};
              v_dec = v_ext - GRAV_X - (bus.duckBtn ? FF_X : '0);
              if (v_dec < TERM_NEG)
                v_d = TERM_NEG[VW-1:0];
              else
                v_d = v_dec[VW-1:0];
              state_d = (!v_d[VW-1] && (v_d != '0)) ? S_RISE : S_FALL;
            end
          end
        end
      end
      2'b01: begin
        state_d = state_q;
      end
      default: begin
        state_d    = S_GROUND;
        h_d        = '0;
        v_d        = '0;
        jump_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= S_GROUND;
      h_q            <= '0;
      v_q            <= '0;
      jump_req_q     <= 1'b0;
      jump_btn_dly_q <= 1'b0;
      land_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      h_q            <= h_d;
      v_q            <= v_d;
      jump_req_q     <= jump_req_d;
      jump_btn_dly_q <= jump_btn_dly_d;
      land_q         <= land_d;
    end
  end

  assign bus.Airborne   = (state_q == S_RISE) || (state_q == S_FALL);
  assign bus.onGround   = (state_q == S_GROUND);
  assign bus.isDuck     = (state_q == S_GROUND) && bus.duckBtn && (bus.gameState == 2'b10);
  assign bus.dinoHeight = h_q;
  assign bus.landPulse  = land_q;

endmodule

// File: tb/tb_dino_jump_ctrl.sv
// Bench for dino_jump_ctrl: integer physics model checked every cycle, plus literal
// height/velocity checkpoints for full jump, short hop, fast fall, freeze and reset.
module tb_dino_jump_ctrl;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dino_jump_ctrl_if #(.HW(10)) bus ();
  dino_jump_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  // model: height, velocity (positive = up), airborne flag; rising == airborne && v>0
  int m_h    = 0;
  int m_v    = 0;
  bit m_air  = 1'b0;
  bit m_land = 1'b0;
  bit m_req  = 1'b0;
  bit m_prev = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge rst) begin
    bit rise;
    int v;
    if (!rst) begin
      m_h = 0; m_v = 0; m_air = 0; m_land = 0; m_req = 0; m_prev = 0;
    end else begin
      rise   = bus.jumpBtn && !m_prev;
      m_land = 0;
      case (bus.gameState)
        2'b00, 2'b11: begin
          m_h = 0; m_v = 0; m_air = 0; m_req = 0;
        end
        2'b01: m_req = bus.frameTick ? 1'b0 : (m_req || rise);
        default: begin
          if (!bus.frameTick) begin
            m_req = m_req || rise;
          end else begin
            if (!m_air) begin
              if (m_req || rise) begin
                m_air = 1; m_v = 14;
              end
            end else begin
              v = m_v;
              if (v > 6 && !bus.jumpBtn) v = 6;
              if (m_h + v <= 0) begin
                m_h = 0; m_v = 0; m_air = 0; m_land = 1;
              end else begin
                m_h = m_h + v;
                m_v = v - 1 - (bus.duckBtn ? 3 : 0);
                if (m_v < -15) m_v = -15;
              end
            end
            m_req = 0;
          end
        end
      endcase
      m_prev = bus.jumpBtn;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("height",     int'(bus.dinoHeight), m_h);
      chk("airborne",   int'(bus.Airborne),   int'(m_air));
      chk("on_ground",  int'(bus.onGround),   int'(!m_air));
      chk("is_duck",    int'(bus.isDuck),     int'(!m_air && bus.duckBtn && bus.gameState == 2'b10));
      chk("land_pulse", int'(bus.landPulse),  int'(m_land));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // one idle cycle, then a single-cycle frame strobe; returns with the update visible
  task automatic tick();
    step();
    bus.frameTick = 1'b1;
    step();
    bus.frameTick = 1'b0;
  endtask

  initial begin
    rst           = 1'b0;
    bus.frameTick = 1'b0;
    bus.gameState = 2'b00;
    bus.jumpBtn   = 1'b0;
    bus.duckBtn   = 1'b0;
    #1 chk_en = 1'b1;
    repeat (2) step();
    rst = 1'b1;
    step();
    chk("rst_on_ground", int'(bus.onGround), 1);
    chk("rst_airborne",  int'(bus.Airborne), 0);
    chk("rst_height",    int'(bus.dinoHeight), 0);
    bus.gameState = 2'b10;
    step();

    // full jump with the button held
    bus.jumpBtn = 1'b1;
    step();
    tick();
    chk("launch_air", int'(bus.Airborne), 1);
    chk("launch_h",   int'(bus.dinoHeight), 0);
    tick();
    chk("tick1_h", int'(bus.dinoHeight), 14);
    chk("tick1_v", m_v, 13);
    for (int i = 2; i <= 14; i++) tick();
    chk("apex_h", int'(bus.dinoHeight), 105);
    chk("apex_v", m_v, 0);
    for (int i = 15; i <= 28; i++) tick();
    chk("tick28_h", int'(bus.dinoHeight), 14);
    tick();
    chk("land_h",      int'(bus.dinoHeight), 0);
    chk("land_pulse1", int'(bus.landPulse), 1);
    chk("land_ground", int'(bus.onGround), 1);
    step();
    chk("land_pulse_drop", int'(bus.landPulse), 0);
    tick();
    tick();
    chk("no_relaunch", int'(bus.onGround), 1);

    // press between ticks is latched, then apex and fast fall
    bus.jumpBtn = 1'b0;
    step();
    bus.jumpBtn = 1'b1;
    step();
    step();
    tick();
    chk("latched_launch", int'(bus.Airborne), 1);
    for (int i = 1; i <= 14; i++) tick();
    chk("apex2_h", int'(bus.dinoHeight), 105);
    bus.duckBtn = 1'b1;
    bus.jumpBtn = 1'b0;
    tick();
    chk("ff1_h", int'(bus.dinoHeight), 105);
    chk("ff1_v", m_v, -4);
    tick();
    chk("ff2_h", int'(bus.dinoHeight), 101);
    chk("ff2_v", m_v, -8);
    tick();
    chk("ff3_h", int'(bus.dinoHeight), 93);
    chk("ff3_v", m_v, -12);
    tick();
    chk("ff4_h", int'(bus.dinoHeight), 81);
    chk("ff4_v_sat", m_v, -15);
    tick();
    chk("ff5_h", int'(bus.dinoHeight), 66);
    for (int i = 0; i < 10 && bus.Airborne; i++) tick();
    chk("ff_grounded",    int'(bus.onGround), 1);
    chk("duck_on_ground", int'(bus.isDuck), 1);
    bus.duckBtn = 1'b0;
    step();
    chk("duck_release", int'(bus.isDuck), 0);

    // short hop
    bus.jumpBtn = 1'b1;
    step();
    tick();
    tick();
    tick();
    chk("hop_h", int'(bus.dinoHeight), 27);
    chk("hop_v", m_v, 12);
    bus.jumpBtn = 1'b0;
    tick();
    chk("hop_cap_h", int'(bus.dinoHeight), 33);
    chk("hop_cap_v", m_v, 5);
    for (int i = 0; i < 40 && bus.Airborne; i++) tick();
    chk("hop_grounded", int'(bus.onGround), 1);

    // freeze mid-air, then return to start
    bus.jumpBtn = 1'b1;
    step();
    tick();
    repeat (5) tick();
    chk("pre_freeze_h", int'(bus.dinoHeight), 60);
    bus.gameState = 2'b01;
    repeat (10) tick();
    chk("freeze_h",   int'(bus.dinoHeight), 60);
    chk("freeze_air", int'(bus.Airborne), 1);
    bus.gameState = 2'b00;
    step();
    chk("start_clear_h",      int'(bus.dinoHeight), 0);
    chk("start_clear_ground", int'(bus.onGround), 1);
    bus.jumpBtn   = 1'b0;
    bus.gameState = 2'b10;
    step();

    // asynchronous reset mid-jump
    bus.jumpBtn = 1'b1;
    step();
    tick();
    repeat (4) tick();
    chk("pre_rst_h", int'(bus.dinoHeight), 50);
    #2 rst = 1'b0;
    #1;
    chk("arst_h",      int'(bus.dinoHeight), 0);
    chk("arst_ground", int'(bus.onGround), 1);
    chk("arst_air",    int'(bus.Airborne), 0);
    chk("arst_land",   int'(bus.landPulse), 0);
    step();
    rst         = 1'b1;
    bus.jumpBtn = 1'b0;
    step();
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
